calc_nport_top: RTL and testbench
=================================

Name: calc_nport_top

Overview:
- Parametrised successor to the four-port calc1 calculator.
- NUM_PORTS requester ports each capture two-cycle commands (command+operand1, then operand2) with a tag into a per-port queue.
- A round-robin arbiter feeds one shared ALU; each result is returned on the originating port with the tag echoed.
- Adds backpressure (req_ready), queueing depth, tags and a distinct invalid-command response.

Parameters:
NUM_PORTS, 4, number of requester ports (2..8)
DATA_W, 32, operand/result width (power of 2, 8..64)
TAG_W, 2, request tag width
DEPTH, 4, per-port queue entries (power of 2, >=2)

Ports:
c_clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
req_cmd_in  input  NUM_PORTS*4  per-port command; port p at slice p
req_data_in  input  NUM_PORTS*DATA_W  per-port operand
req_tag_in  input  NUM_PORTS*TAG_W  per-port tag, sampled in the command cycle
req_ready  output  NUM_PORTS  port p may present a new command this cycle
out_resp  output  NUM_PORTS*2  per-port response code, one-cycle pulse
out_data  output  NUM_PORTS*DATA_W  per-port result
out_tag  output  NUM_PORTS*TAG_W  per-port echoed tag

Behaviour:
- Commands: 1 add, 2 sub, 5 shift left, 6 shift right; 0 no-op; all other values invalid.
- Responses: 0 none, 1 success, 2 overflow/underflow, 3 invalid command.
- Reset (reset=0, async): all outputs 0, queues empty, capture FSMs IDLE, RR pointer at port 0. Mid-operation reset discards all in-flight and queued requests; no response is ever issued for them.
- Capture FSM per port, IDLE / WAIT_OP2:
  - IDLE: cmd!=0 and req_ready=1 at an edge -> latch cmd, tag, operand1 -> WAIT_OP2.
  - IDLE: cmd!=0 with req_ready=0 -> dropped silently; no response.
  - WAIT_OP2: next edge latches operand2 unconditionally (cmd ignored), pushes the entry and returns to IDLE.
- Back-to-back commands on a port are legal every second cycle.
- req_ready = (queue count + (state==WAIT_OP2)) < DEPTH; operand2 therefore never overflows the queue.
- Arbiter:
  - Each cycle grants one non-empty queue, searching from the RR pointer.
  - After a grant the pointer becomes grant+1 mod NUM_PORTS.
  - The granted queue pops; the ALU result is registered.
- Latency: operand2 sampled at edge E, uncontended -> out_resp/out_data/out_tag valid for exactly one cycle after edge E+1. Under contention each port keeps FIFO order.
- Non-responding ports drive resp 0, data 0, tag 0.
- ALU, unsigned:
  - Add: carry out -> resp 2, data 0.
  - Sub: operand2>operand1 -> resp 2, data 0; equal operands -> resp 1, data 0.
  - Shift left/right: operand1 shifted by the low log2(DATA_W) bits of operand2, zero fill, always resp 1.
  - Invalid command -> resp 3, data 0, tag still echoed.
- Simultaneous pushes on all ports are accepted in the same cycle; only one response is issued per cycle in total.

Decomposition:
- Shared package calc_pkg holds:
  - Command encodings: CMD_NOP, CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR.
  - Response encodings: RESP_NONE, RESP_OK, RESP_OVF, RESP_INV.
  - Queue entry layout: cmd, tag, operand1, operand2.
- Sub-module calc_req_port: capture FSM, queue storage, count and req_ready; instantiated NUM_PORTS times.
- Arbiter and ALU stay in the top.

Test Plan (defaults):
- Port0 add, operand1 0x0000001A, operand2 0x00000005, tag 2 -> port0 resp 1, data 0x0000001F, tag 2, one cycle after edge E+1.
- Port3 sub 0x00000005-0x00000009 -> resp 2, data 0. Port1 add 0xFFFFFFFF+0x00000001 -> resp 2, data 0. Port2 sub 0x00000007-0x00000007 -> resp 1, data 0.
- Port1 shl 0x00000001 by 0x00000021 -> resp 1, data 0x00000002. Port1 shr 0x80000000 by 31 -> data 0x00000001. Port0 cmd 7 -> resp 3, data 0, tag echoed.
- All four ports issue add (n+1) in the same cycle -> responses on four consecutive cycles in order port0, port1, port2, port3, each on its own port with correct sums.
- All ports issue back-to-back adds for 24 cycles:
  - req_ready deasserts once queues fill.
  - Commands presented with ready=0 yield no response.
  - Responses equal accepted commands, in per-port order.
  - Tags stay intact throughout.
- Reset asserted while queues are half full and one port is in WAIT_OP2 -> all outputs 0 immediately, no stale responses after release, and a fresh add afterwards returns the correct result.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared command/response encodings and queue entry layout for calc_nport_top
package calc_pkg;

  localparam int CMD_W  = 4;
  localparam int RESP_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_OVF  = 2'd2,
    RESP_INV  = 2'd3
  } resp_e;

  // Queue entry packs {cmd, tag, operand1, operand2}, operand2 in the LSBs.
  function automatic int entry_w(int data_w, int tag_w);
    return CMD_W + tag_w + 2 * data_w;
  endfunction

endpackage

// File: rtl/calc_nport_top_if.sv
// rtl/calc_nport_top_if.sv - requester/response bundle for calc_nport_top
interface calc_nport_top_if
  import calc_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 2
);

  logic [NUM_PORTS*CMD_W-1:0]  req_cmd_in;
  logic [NUM_PORTS*DATA_W-1:0] req_data_in;
  logic [NUM_PORTS*TAG_W-1:0]  req_tag_in;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS*RESP_W-1:0] out_resp;
  logic [NUM_PORTS*DATA_W-1:0] out_data;
  logic [NUM_PORTS*TAG_W-1:0]  out_tag;

  modport master (
    output req_cmd_in, req_data_in, req_tag_in,
    input  req_ready, out_resp, out_data, out_tag
  );

  modport slave (
    input  req_cmd_in, req_data_in, req_tag_in,
    output req_ready, out_resp, out_data, out_tag
  );

endinterface

// File: rtl/calc_req_port.sv
// rtl/calc_req_port.sv - per-port two-cycle command capture FSM feeding a request queue
module calc_req_port
  import calc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 2,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CMD_W-1:0]  cmd,
  input  logic [DATA_W-1:0] data,
  input  logic [TAG_W-1:0]  tag,
  output logic              ready,
  input  logic              pop,
  output logic              valid,
  output logic [CMD_W-1:0]  head_cmd,
  output logic [TAG_W-1:0]  head_tag,
  output logic [DATA_W-1:0] head_op1,
  output logic [DATA_W-1:0] head_op2
);

  localparam int EW = entry_w(DATA_W, TAG_W);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, WAIT_OP2} state_e;

  state_e            state, state_nx;
  logic [CMD_W-1:0]  cmd_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] op1_q;
  logic [EW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic [AW+1:0]     occupancy;
  logic              capture, push, pop_ok;

  // A pending operand2 reserves its slot, so the push can never overflow.
  assign occupancy = {1'b0, count} + (AW+2)'(state == WAIT_OP2);
  assign ready     = occupancy < (AW+2)'(DEPTH);
  assign valid     = count != '0;
  assign pop_ok    = pop && valid;

  assign {head_cmd, head_tag, head_op1, head_op2} = mem[rd_ptr];

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    push     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd != CMD_NOP && ready) begin
          capture  = 1'b1;
          state_nx = WAIT_OP2;
        end
      end
      WAIT_OP2: begin
        push     = 1'b1;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cmd_q  <= '0;
      tag_q  <= '0;
      op1_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nx;
      if (capture) begin
        cmd_q <= cmd;
        tag_q <= tag;
        op1_q <= data;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_q, tag_q, op1_q, data};
  end

endmodule

// File: rtl/calc_nport_top.sv
// rtl/calc_nport_top.sv - N-port tagged calculator: per-port queues, round-robin arbiter, shared ALU
module calc_nport_top
  import calc_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 2,
  parameter int DEPTH     = 4
) (
  input logic              c_clk,
  input logic              reset,
  calc_nport_top_if.slave  bus
);

  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int SHW = $clog2(DATA_W);

  logic [NUM_PORTS-1:0] valid, pop;
  logic [CMD_W-1:0]     h_cmd [NUM_PORTS];
  logic [TAG_W-1:0]     h_tag [NUM_PORTS];
  logic [DATA_W-1:0]    h_op1 [NUM_PORTS];
  logic [DATA_W-1:0]    h_op2 [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    calc_req_port #(
      .DATA_W (DATA_W),
      .TAG_W  (TAG_W),
      .DEPTH  (DEPTH)
    ) u_port (
      .clk      (c_clk),
      .rst_n    (reset),
      .cmd      (bus.req_cmd_in[p*CMD_W +: CMD_W]),
      .data     (bus.req_data_in[p*DATA_W +: DATA_W]),
      .tag      (bus.req_tag_in[p*TAG_W +: TAG_W]),
      .ready    (bus.req_ready[p]),
      .pop      (pop[p]),
      .valid    (valid[p]),
      .head_cmd (h_cmd[p]),
      .head_tag (h_tag[p]),
      .head_op1 (h_op1[p]),
      .head_op2 (h_op2[p])
    );
  end

  logic [PW-1:0] rr_ptr, gnt_idx;
  logic          gnt_any;
  logic [PW:0]   idx;

  // Search starts at rr_ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(NUM_PORTS)) idx = idx - (PW+1)'(NUM_PORTS);
      if (!gnt_any && valid[idx[PW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[PW-1:0];
      end
    end
  end

  assign pop = gnt_any ? (NUM_PORTS'(1) << gnt_idx) : '0;

  logic [CMD_W-1:0]  a_cmd;
  logic [TAG_W-1:0]  a_tag;
  logic [DATA_W-1:0] a_op1, a_op2;
  logic [DATA_W:0]   sum;
  logic [RESP_W-1:0] alu_resp;
  logic [DATA_W-1:0] alu_data;

  assign a_cmd = h_cmd[gnt_idx];
  assign a_tag = h_tag[gnt_idx];
  assign a_op1 = h_op1[gnt_idx];
  assign a_op2 = h_op2[gnt_idx];
  assign sum   = {1'b0, a_op1} + {1'b0, a_op2};

  always_comb begin
    alu_resp = RESP_INV;
    alu_data = '0;
    case (a_cmd)
      CMD_ADD: begin
        if (sum[DATA_W]) begin
          alu_resp = RESP_OVF;
        end else begin
          alu_resp = RESP_OK;
          alu_data = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (a_op2 > a_op1) begin
          alu_resp = RESP_OVF;
        end else begin
          alu_resp = RESP_OK;
          alu_data = a_op1 - a_op2;
        end
      end
      CMD_SHL: begin
        alu_resp = RESP_OK;
        alu_data = a_op1 << a_op2[SHW-1:0];
      end
      CMD_SHR: begin
        alu_resp = RESP_OK;
        alu_data = a_op1 >> a_op2[SHW-1:0];
      end
      default: begin
        alu_resp = RESP_INV;
        alu_data = '0;
      end
    endcase
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rr_ptr       <= '0;
      bus.out_resp <= '0;
      bus.out_data <= '0;
      bus.out_tag  <= '0;
    end else begin
      bus.out_resp <= '0;
      bus.out_data <= '0;
      bus.out_tag  <= '0;
      if (gnt_any) begin
        bus.out_resp[gnt_idx*RESP_W +: RESP_W] <= alu_resp;
        bus.out_data[gnt_idx*DATA_W +: DATA_W] <= alu_data;
        bus.out_tag[gnt_idx*TAG_W +: TAG_W]    <= a_tag;
        rr_ptr <= (gnt_idx == PW'(NUM_PORTS-1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_calc_nport_top.sv
// tb/tb_calc_nport_top.sv - directed self-checking bench for calc_nport_top
module tb_calc_nport_top;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int TW = 2;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  calc_nport_top_if #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW)) bus ();

  calc_nport_top #(.NUM_PORTS(NP), .DATA_W(DW), .TAG_W(TW), .DEPTH(DP)) dut (
    .c_clk (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  logic [3:0]    cmd_v [NP];
  logic [DW-1:0] dat_v [NP];
  logic [TW-1:0] tag_v [NP];

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      bus.req_cmd_in[p*4 +: 4]    = cmd_v[p];
      bus.req_data_in[p*DW +: DW] = dat_v[p];
      bus.req_tag_in[p*TW +: TW]  = tag_v[p];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int            port;
    logic [3:0]    cmd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [TW-1:0] tag;
    logic [1:0]    resp;
    logic [DW-1:0] data;
  } vec_t;

  task automatic idle_inputs();
    for (int p = 0; p < NP; p++) begin
      cmd_v[p] = 4'd0;
      dat_v[p] = '0;
      tag_v[p] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.out_resp !== '0) begin
      miscompares++;
      $display("FAIL reset_resp got %h exp 0", bus.out_resp);
    end
    vectors++;
    if (bus.out_data !== '0) begin
      miscompares++;
      $display("FAIL reset_data got %h exp 0", bus.out_data);
    end
    vectors++;
    if (bus.out_tag !== '0) begin
      miscompares++;
      $display("FAIL reset_tag got %h exp 0", bus.out_tag);
    end
    vectors++;
    if (bus.req_ready !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_ready got %h exp f", bus.req_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_alu();
    vec_t tbl [7];
    logic [NP*2-1:0]  er;
    logic [NP*DW-1:0] ed;
    logic [NP*TW-1:0] et;
    tbl[0] = '{0, 4'd1, 32'h0000001A, 32'h00000005, 2'd2, 2'd1, 32'h0000001F};
    tbl[1] = '{3, 4'd2, 32'h00000005, 32'h00000009, 2'd1, 2'd2, 32'h00000000};
    tbl[2] = '{1, 4'd1, 32'hFFFFFFFF, 32'h00000001, 2'd3, 2'd2, 32'h00000000};
    tbl[3] = '{2, 4'd2, 32'h00000007, 32'h00000007, 2'd0, 2'd1, 32'h00000000};
    tbl[4] = '{1, 4'd5, 32'h00000001, 32'h00000021, 2'd1, 2'd1, 32'h00000002};
    tbl[5] = '{1, 4'd6, 32'h80000000, 32'h0000001F, 2'd2, 2'd1, 32'h00000001};
    tbl[6] = '{0, 4'd7, 32'h00000000, 32'h00000000, 2'd3, 2'd3, 32'h00000000};
    for (int i = 0; i < 7; i++) begin
      tick();
      cmd_v[tbl[i].port] = tbl[i].cmd;
      dat_v[tbl[i].port] = tbl[i].a;
      tag_v[tbl[i].port] = tbl[i].tag;
      tick();
      cmd_v[tbl[i].port] = 4'd0;
      dat_v[tbl[i].port] = tbl[i].b;
      @(posedge clk);
      #1;
      idle_inputs();
      @(negedge clk);
      vectors++;
      if (bus.out_resp !== '0) begin
        miscompares++;
        $display("FAIL alu%0d_early got %h exp 0", i, bus.out_resp);
      end
      er = '0; ed = '0; et = '0;
      er[tbl[i].port*2 +: 2]   = tbl[i].resp;
      ed[tbl[i].port*DW +: DW] = tbl[i].data;
      et[tbl[i].port*TW +: TW] = tbl[i].tag;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (bus.out_resp !== er) begin
        miscompares++;
        $display("FAIL alu%0d_resp got %h exp %h", i, bus.out_resp, er);
      end
      vectors++;
      if (bus.out_data !== ed) begin
        miscompares++;
        $display("FAIL alu%0d_data got %h exp %h", i, bus.out_data, ed);
      end
      vectors++;
      if (bus.out_tag !== et) begin
        miscompares++;
        $display("FAIL alu%0d_tag got %h exp %h", i, bus.out_tag, et);
      end
      @(negedge clk);
      vectors++;
      if (bus.out_resp !== '0) begin
        miscompares++;
        $display("FAIL alu%0d_pulse got %h exp 0", i, bus.out_resp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [NP*2-1:0]  er;
    logic [NP*DW-1:0] ed;
    logic [NP*TW-1:0] et;
    apply_reset();
    tick();
    for (int p = 0; p < NP; p++) begin
      cmd_v[p] = 4'd1;
      dat_v[p] = DW'(32'h100 * (p + 1));
      tag_v[p] = TW'(p);
    end
    tick();
    for (int p = 0; p < NP; p++) begin
      cmd_v[p] = 4'd0;
      dat_v[p] = DW'(p + 1);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    for (int k = 0; k < NP; k++) begin
      @(posedge clk);
      @(negedge clk);
      er = '0; ed = '0; et = '0;
      er[k*2 +: 2]   = 2'd1;
      ed[k*DW +: DW] = DW'(32'h101 * (k + 1));
      et[k*TW +: TW] = TW'(k);
      vectors++;
      if (bus.out_resp !== er) begin
        miscompares++;
        $display("FAIL simul%0d_resp got %h exp %h", k, bus.out_resp, er);
      end
      vectors++;
      if (bus.out_data !== ed) begin
        miscompares++;
        $display("FAIL simul%0d_data got %h exp %h", k, bus.out_data, ed);
      end
      vectors++;
      if (bus.out_tag !== et) begin
        miscompares++;
        $display("FAIL simul%0d_tag got %h exp %h", k, bus.out_tag, et);
      end
    end
    @(negedge clk);
    vectors++;
    if (bus.out_resp !== '0) begin
      miscompares++;
      $display("FAIL simul_tail got %h exp 0", bus.out_resp);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d [NP][$];
    logic [TW-1:0] exp_t [NP][$];
    int  accepted = 0;
    int  received = 0;
    int  drops = 0;
    int  first_ready_ok = 1;
    bit  stim_done = 0;
    fork
      begin
        for (int cyc = 0; cyc < 24; cyc++) begin
          tick();
          for (int p = 0; p < NP; p++) begin
            if (cyc % 2 == 0) begin
              if (bus.req_ready[p]) begin
                exp_d[p].push_back(DW'((p << 8) | (cyc / 2)) + DW'(cyc / 2 + 1));
                exp_t[p].push_back(TW'(cyc / 2 + p));
                accepted++;
              end else begin
                drops++;
                if (cyc == 0) first_ready_ok = 0;
              end
              cmd_v[p] = 4'd1;
              dat_v[p] = DW'((p << 8) | (cyc / 2));
              tag_v[p] = TW'(cyc / 2 + p);
            end else begin
              cmd_v[p] = 4'd0;
              dat_v[p] = DW'(cyc / 2 + 1);
            end
          end
        end
        tick();
        idle_inputs();
        stim_done = 1;
      end
      begin
        for (int c = 0; c < 150; c++) begin
          int active;
          @(negedge clk);
          active = 0;
          for (int p = 0; p < NP; p++) begin
            if (bus.out_resp[p*2 +: 2] != 2'd0) begin
              active++;
              received++;
              vectors++;
              if (exp_d[p].size() == 0) begin
                miscompares++;
                $display("FAIL b2b_unexpected port %0d got resp %0d exp none", p, bus.out_resp[p*2 +: 2]);
              end else begin
                if (bus.out_resp[p*2 +: 2] !== 2'd1 || bus.out_data[p*DW +: DW] !== exp_d[p][0]) begin
                  miscompares++;
                  $display("FAIL b2b_data port %0d got resp %0d data %h exp resp 1 data %h", p,
                           bus.out_resp[p*2 +: 2], bus.out_data[p*DW +: DW], exp_d[p][0]);
                end
                vectors++;
                if (bus.out_tag[p*TW +: TW] !== exp_t[p][0]) begin
                  miscompares++;
                  $display("FAIL b2b_tag port %0d got %0d exp %0d", p, bus.out_tag[p*TW +: TW], exp_t[p][0]);
                end
                void'(exp_d[p].pop_front());
                void'(exp_t[p].pop_front());
              end
            end
          end
          vectors++;
          if (active > 1) begin
            miscompares++;
            $display("FAIL b2b_one_per_cycle got %0d exp <=1", active);
          end
          if (stim_done && exp_d[0].size() == 0 && exp_d[1].size() == 0 &&
              exp_d[2].size() == 0 && exp_d[3].size() == 0) break;
        end
      end
    join
    repeat (4) @(negedge clk);
    vectors++;
    if (received !== accepted) begin
      miscompares++;
      $display("FAIL b2b_count got %0d exp %0d", received, accepted);
    end
    vectors++;
    if (drops == 0) begin
      miscompares++;
      $display("FAIL b2b_backpressure got %0d drops exp >0", drops);
    end
    vectors++;
    if (first_ready_ok != 1) begin
      miscompares++;
      $display("FAIL b2b_first_ready got %0d exp 1", first_ready_ok);
    end
    vectors++;
    if (bus.out_resp !== '0) begin
      miscompares++;
      $display("FAIL b2b_drained got %h exp 0", bus.out_resp);
    end
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r < 2; r++) begin
      tick();
      for (int p = 0; p < NP; p++) begin
        cmd_v[p] = 4'd1;
        dat_v[p] = DW'(r + 10);
        tag_v[p] = TW'(r);
      end
      tick();
      for (int p = 0; p < NP; p++) begin
        cmd_v[p] = 4'd0;
        dat_v[p] = DW'(p);
      end
    end
    tick();
    idle_inputs();
    cmd_v[2] = 4'd1;
    dat_v[2] = DW'(99);
    tick();
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_resp !== '0 || bus.out_data !== '0 || bus.out_tag !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs got %h/%h/%h exp 0", bus.out_resp, bus.out_data, bus.out_tag);
    end
    vectors++;
    if (bus.req_ready !== 4'hF) begin
      miscompares++;
      $display("FAIL midreset_ready got %h exp f", bus.req_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      vectors++;
      if (bus.out_resp !== '0) begin
        miscompares++;
        $display("FAIL midreset_stale%0d got %h exp 0", c, bus.out_resp);
      end
    end
    tick();
    cmd_v[2] = 4'd1;
    dat_v[2] = 32'h12345678;
    tag_v[2] = 2'd1;
    tick();
    cmd_v[2] = 4'd0;
    dat_v[2] = 32'h11111111;
    @(posedge clk);
    #1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (bus.out_resp !== 8'h10) begin
      miscompares++;
      $display("FAIL fresh_resp got %h exp 10", bus.out_resp);
    end
    vectors++;
    if (bus.out_data[2*DW +: DW] !== 32'h23456789) begin
      miscompares++;
      $display("FAIL fresh_data got %h exp 23456789", bus.out_data[2*DW +: DW]);
    end
    vectors++;
    if (bus.out_tag !== 8'h10) begin
      miscompares++;
      $display("FAIL fresh_tag got %h exp 10", bus.out_tag);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_alu();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
